// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mc_controller_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             step;
    logic             pcen;
    logic             irwrite;
    logic             memwrite;
    logic             regwrite;
    logic             iord;
    logic             memtoreg;
    logic             regdst;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [2:0]       alucontrol;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero, step,
        output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal, instr_count
    );

    modport slave (
        output opcode, funct, zero, step,
        input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, state, illegal, instr_count
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with ALU decode and retired-instruction counter.
// Optional MC_SINGLE_STEP_EN: FETCH holds until a step pulse.
module mc_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_controller_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_NONE  = 2'd0,
        ALU_ADD   = 2'd1,
        ALU_SUB   = 2'd2,
        ALU_FUNCT = 2'd3
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           state_q, state_d;
    aluop_t           aluop;
    logic             fetch_go;
    logic             pcwrite, branch, retire;
    logic             irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0]       alusrcb, pcsrc;
    logic [2:0]       alucontrol;
    logic [CNT_W-1:0] count_q;

`ifdef MC_SINGLE_STEP_EN
    assign fetch_go = bus.step;
`else
    logic unused_step;
    assign unused_step = bus.step;
    assign fetch_go    = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = fetch_go ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            default:  state_d = FETCH;
        endcase
    end

    // Everything is gated by reset so the outputs read 0 while it is held low.
    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALU_NONE;
        illegal  = 1'b0;
        retire   = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: if (fetch_go) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    alusrcb = 2'b01;
                    aluop   = ALU_ADD;
                end
                DECODE: begin
                    alusrcb = 2'b11;
                    aluop   = ALU_ADD;
                    illegal = !(bus.opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
                end
                MEMADR, ADDIEXEC: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluop   = ALU_ADD;
                end
                MEMRD:   iord = 1'b1;
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                    retire   = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                    retire   = 1'b1;
                end
                EXECUTE: begin
                    alusrca = 1'b1;
                    aluop   = ALU_FUNCT;
                end
                ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                    retire   = 1'b1;
                end
                BRANCH: begin
                    alusrca = 1'b1;
                    branch  = 1'b1;
                    pcsrc   = 2'b01;
                    aluop   = ALU_SUB;
                    retire  = 1'b1;
                end
                ADDIWB: begin
                    regwrite = 1'b1;
                    retire   = 1'b1;
                end
                JUMP: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                    retire  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            ALU_ADD: alucontrol = 3'b010;
            ALU_SUB: alucontrol = 3'b110;
            ALU_FUNCT: begin
                case (bus.funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      count_q <= '0;
        else if (retire) count_q <= count_q + CNT_W'(1);
    end

    assign bus.pcen        = pcwrite | (branch & bus.zero);
    assign bus.irwrite     = irwrite;
    assign bus.memwrite    = memwrite;
    assign bus.regwrite    = regwrite;
    assign bus.iord        = iord;
    assign bus.memtoreg    = memtoreg;
    assign bus.regdst      = regdst;
    assign bus.alusrca     = alusrca;
    assign bus.alusrcb     = alusrcb;
    assign bus.pcsrc       = pcsrc;
    assign bus.alucontrol  = alucontrol;
    assign bus.state       = state_q;
    assign bus.illegal     = illegal;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed instruction sequences, per-cycle expected outputs.
module tb_mc_controller;
    typedef struct {
        string       nm;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    // ctl = {pcen,irwrite,memwrite,regwrite, iord,memtoreg,regdst,alusrca, alusrcb,pcsrc, alucontrol,illegal}
    localparam logic [15:0] C_ZERO     = 16'b0000_0000_0000_0000;
    localparam logic [15:0] C_FETCH    = 16'b1100_0000_0100_0100;
    localparam logic [15:0] C_DECODE   = 16'b0000_0000_1100_0100;
    localparam logic [15:0] C_DEC_ILL  = 16'b0000_0000_1100_0101;
    localparam logic [15:0] C_MEMADR   = 16'b0000_0001_1000_0100;
    localparam logic [15:0] C_MEMRD    = 16'b0000_1000_0000_0000;
    localparam logic [15:0] C_MEMWB    = 16'b0001_0100_0000_0000;
    localparam logic [15:0] C_MEMWR    = 16'b0010_1000_0000_0000;
    localparam logic [15:0] C_ALUWB    = 16'b0001_0010_0000_0000;
    localparam logic [15:0] C_BEQ_Z1   = 16'b1000_0001_0001_1100;
    localparam logic [15:0] C_BEQ_Z0   = 16'b0000_0001_0001_1100;
    localparam logic [15:0] C_ADDIWB   = 16'b0001_0000_0000_0000;
    localparam logic [15:0] C_JUMP     = 16'b1000_0000_0010_0000;

`ifdef MC_SINGLE_STEP_EN
    localparam logic STEP_DEF = 1'b1;
`else
    localparam logic STEP_DEF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic p_reset, p_step, p_zero;
    logic [5:0] p_op, p_fn;
    logic [31:0] exp_cnt;
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t q[$];

    mc_controller_if #(.CNT_W(32)) bus ();
    mc_controller #(.CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [15:0] c_exec(input logic [2:0] alu);
        return {8'b0000_0001, 4'b0000, alu, 1'b0};
    endfunction

    // Apply pending inputs just after the falling edge, then queue what this cycle must show.
    task automatic cyc(input string nm, input logic [3:0] st, input logic [15:0] ctl);
        exp_t e;
        @(negedge clk);
        #1;
        reset      = p_reset;
        bus.step   = p_step;
        bus.opcode = p_op;
        bus.funct  = p_fn;
        bus.zero   = p_zero;
        e.nm  = nm;
        e.st  = st;
        e.ctl = ctl;
        e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [15:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e   = q.pop_front();
                act = {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite,
                       bus.iord, bus.memtoreg, bus.regdst, bus.alusrca,
                       bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.illegal};
                checks++;
                if (bus.state !== e.st || act !== e.ctl || bus.instr_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s: got state=%0d ctl=%b cnt=%0d, want state=%0d ctl=%b cnt=%0d",
                             e.nm, bus.state, act, bus.instr_count, e.st, e.ctl, e.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        reset = 1'b0; bus.step = STEP_DEF; bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0;
        p_reset = 1'b0; p_step = STEP_DEF; p_op = '0; p_fn = '0; p_zero = 1'b0;
        exp_cnt = 0;

        repeat (3) cyc("reset", 4'd0, C_ZERO);
        p_reset = 1'b1;

        p_op = 6'b100011;
        cyc("lw fetch", 4'd0, C_FETCH);   cyc("lw decode", 4'd1, C_DECODE);
        cyc("lw memadr", 4'd2, C_MEMADR); cyc("lw memrd", 4'd3, C_MEMRD);
        cyc("lw memwb", 4'd4, C_MEMWB);   exp_cnt = 1;

        p_op = 6'b101011;
        cyc("sw fetch", 4'd0, C_FETCH);   cyc("sw decode", 4'd1, C_DECODE);
        cyc("sw memadr", 4'd2, C_MEMADR); cyc("sw memwr", 4'd5, C_MEMWR);
        exp_cnt = 2;

        p_op = 6'b000000; p_fn = 6'b101010;
        cyc("slt fetch", 4'd0, C_FETCH); cyc("slt decode", 4'd1, C_DECODE);
        cyc("slt exec", 4'd6, c_exec(3'b111)); cyc("slt aluwb", 4'd7, C_ALUWB);
        exp_cnt = 3;

        p_fn = 6'b100100;
        cyc("and fetch", 4'd0, C_FETCH); cyc("and decode", 4'd1, C_DECODE);
        cyc("and exec", 4'd6, c_exec(3'b000)); cyc("and aluwb", 4'd7, C_ALUWB);
        exp_cnt = 4;

        p_fn = 6'b100101;
        cyc("or fetch", 4'd0, C_FETCH); cyc("or decode", 4'd1, C_DECODE);
        cyc("or exec", 4'd6, c_exec(3'b001)); cyc("or aluwb", 4'd7, C_ALUWB);
        exp_cnt = 5;

        p_fn = 6'b000111;
        cyc("unk fetch", 4'd0, C_FETCH); cyc("unk decode", 4'd1, C_DECODE);
        cyc("unk exec", 4'd6, c_exec(3'b010)); cyc("unk aluwb", 4'd7, C_ALUWB);
        exp_cnt = 6;

        p_op = 6'b001000;
        cyc("addi fetch", 4'd0, C_FETCH);  cyc("addi decode", 4'd1, C_DECODE);
        cyc("addi exec", 4'd9, C_MEMADR);  cyc("addi wb", 4'd10, C_ADDIWB);
        exp_cnt = 7;

        p_op = 6'b000100; p_zero = 1'b1;
        cyc("beq1 fetch", 4'd0, C_FETCH); cyc("beq1 decode", 4'd1, C_DECODE);
        cyc("beq1 branch", 4'd8, C_BEQ_Z1);
        exp_cnt = 8;

        p_zero = 1'b0;
        cyc("beq0 fetch", 4'd0, C_FETCH); cyc("beq0 decode", 4'd1, C_DECODE);
        cyc("beq0 branch", 4'd8, C_BEQ_Z0);
        exp_cnt = 9;

        p_op = 6'b111111;
        cyc("ill fetch", 4'd0, C_FETCH); cyc("ill decode", 4'd1, C_DEC_ILL);

        p_op = 6'b000010;
        cyc("j fetch", 4'd0, C_FETCH); cyc("j decode", 4'd1, C_DECODE);
        cyc("j jump", 4'd11, C_JUMP);
        exp_cnt = 10;

        p_op = 6'b000000; p_fn = 6'b100010;
        cyc("sub fetch", 4'd0, C_FETCH); cyc("sub decode", 4'd1, C_DECODE);
        cyc("sub exec", 4'd6, c_exec(3'b110));
        p_reset = 1'b0; exp_cnt = 0;
        repeat (3) cyc("mid reset", 4'd0, C_ZERO);
        p_reset = 1'b1; p_op = 6'b000010;
        cyc("post fetch", 4'd0, C_FETCH); cyc("post decode", 4'd1, C_DECODE);
        cyc("post jump", 4'd11, C_JUMP);
        exp_cnt = 1;

`ifdef MC_SINGLE_STEP_EN
        p_step = 1'b0;
        repeat (5) cyc("step hold", 4'd0, C_ZERO);
        p_step = 1'b1;
        cyc("step fetch", 4'd0, C_FETCH);
        p_step = 1'b0;
        cyc("step decode", 4'd1, C_DECODE); cyc("step jump", 4'd11, C_JUMP);
        exp_cnt = 2;
        cyc("step rehold", 4'd0, C_ZERO);
        p_step = 1'b1;
`endif
        cyc("final fetch", 4'd0, C_FETCH);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
